// File: rtl/serial_signed_adder.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// through a registered-carry ripple slice, with signed overflow, carry-out and saturation.
module serial_signed_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             overflow,
  output logic             cout,
  output logic             dbg_state_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_signed_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Handshake: start is sampled only in IDLE; busy is high from the accept edge until
  // the final digit edge; done is a single-cycle pulse in the cycle results update.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             a_sign_q, a_sign_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   slice_sum;
  logic             slice_msb_cin;
  logic [WIDTH-1:0] slice_w;
  logic [WIDTH-1:0] res_shift;
  logic             last_digit;

  assign slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
  // The carry into the slice's top bit is recovered from that bit's sum and inputs.
  assign slice_msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];
  assign last_digit    = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    slice_w              = '0;
    slice_w[DIGIT-1:0]   = slice_sum[DIGIT-1:0];
    res_shift            = (res_q >> DIGIT) | (slice_w << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    a_sign_d = a_sign_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = A;
          b_d      = B ^ {WIDTH{sub}};
          res_d    = '0;
          carry_d  = sub;
          cnt_d    = '0;
          sat_d    = sat;
          a_sign_d = A[WIDTH-1];
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = IDLE;
          ovf_d   = slice_msb_cin ^ slice_sum[DIGIT];
          cout_d  = slice_sum[DIGIT];
          done_d  = 1'b1;
          if (sat_q && ovf_d) begin
            sum_d = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            sum_d = res_shift;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      a_sign_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      a_sign_q <= a_sign_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign Sum         = sum_q;
  assign overflow    = ovf_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_signed_adder.sv
// Bench for serial_signed_adder: a 4-bit/1-digit and an 8-bit/2-digit instance driven
// with directed and random operations, checked against a signed-integer reference model.
module tb_serial_signed_adder;

  logic clk;
  logic rst;

  logic       start4, sub4, sat4;
  logic [3:0] a4, b4;
  logic       busy4, done4, ovf4, cout4, dbg4;
  logic [3:0] sum4;

  logic       start8, sub8, sat8;
  logic [7:0] a8, b8;
  logic       busy8, done8, ovf8, cout8, dbg8;
  logic [7:0] sum8;

  int checks = 0;
  int errors = 0;
  int held_sum [2];
  bit held_ovf [2];
  bit held_cout[2];

  serial_signed_adder #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .sub(sub4), .sat(sat4),
    .busy(busy4), .done(done4), .Sum(sum4), .overflow(ovf4), .cout(cout4),
    .dbg_state_o(dbg4)
  );

  serial_signed_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .sub(sub8), .sat(sat8),
    .busy(busy8), .done(done8), .Sum(sum8), .overflow(ovf8), .cout(cout8),
    .dbg_state_o(dbg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int obs_sum(input bit s8);
    return s8 ? int'(sum8) : int'(sum4);
  endfunction
  function automatic bit obs_busy(input bit s8);
    return s8 ? busy8 : busy4;
  endfunction
  function automatic bit obs_done(input bit s8);
    return s8 ? done8 : done4;
  endfunction
  function automatic bit obs_ovf(input bit s8);
    return s8 ? ovf8 : ovf4;
  endfunction
  function automatic bit obs_cout(input bit s8);
    return s8 ? cout8 : cout4;
  endfunction
  function automatic bit obs_dbg(input bit s8);
    return s8 ? dbg8 : dbg4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed arithmetic on the operand values.
  function automatic void model(input int w, input int a, input int b, input bit s,
                                input bit st, output int sum, output bit ov, output bit co);
    int mask, half, sa, sb, r, cu;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    r    = s ? sa - sb : sa + sb;
    ov   = (r > half - 1) || (r < -half);
    cu   = s ? a + ((~b) & mask) + 1 : a + b;
    co   = ((cu >> w) & 1) != 0;
    if (st && ov) sum = (sa < 0) ? half : half - 1;
    else          sum = r & mask;
  endfunction

  task automatic drive(input bit s8, input bit st, input int a, input int b,
                       input bit sb, input bit sa_t);
    if (s8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sub8 = sb; sat8 = sa_t;
    end else begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0]; sub4 = sb; sat4 = sa_t;
    end
  endtask

  // Called on a negedge; returns on the done negedge (b2b=1) or one cycle later.
  task automatic run_op(input bit s8, input int a, input int b, input bit sb,
                        input bit st, input bit b2b);
    int w, ndig, lat, bcnt, es;
    bit eo, ec;
    w    = s8 ? 8 : 4;
    ndig = s8 ? 4 : 4;
    model(w, a, b, sb, st, es, eo, ec);
    drive(s8, 1'b1, a, b, sb, st);
    @(negedge clk);
    lat  = 1;
    bcnt = 0;
    chk("done_low_after_accept", obs_done(s8), 0);
    while (!obs_done(s8) && lat < 20) begin
      chk("sum_hold", obs_sum(s8), held_sum[int'(s8)]);
      chk("ovf_hold", obs_ovf(s8), held_ovf[int'(s8)]);
      chk("cout_hold", obs_cout(s8), held_cout[int'(s8)]);
      if (obs_busy(s8)) bcnt++;
      drive(s8, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      lat++;
    end
    drive(s8, 1'b0, a, b, sb, st);
    chk("done_seen", obs_done(s8), 1);
    chk("latency_edges", lat, ndig + 1);
    chk("busy_cycles", bcnt, ndig);
    chk("busy_at_done", obs_busy(s8), 0);
    chk("sum", obs_sum(s8), es);
    chk("overflow", obs_ovf(s8), eo);
    chk("cout", obs_cout(s8), ec);
    held_sum[int'(s8)]  = es;
    held_ovf[int'(s8)]  = eo;
    held_cout[int'(s8)] = ec;
    if (!b2b) begin
      @(negedge clk);
      chk("done_one_cycle", obs_done(s8), 0);
      chk("sum_after_done", obs_sum(s8), es);
      chk("idle_after_done", obs_dbg(s8), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      held_sum[k] = 0; held_ovf[k] = 1'b0; held_cout[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", obs_busy(k[0]), 0);
      chk("reset_done", obs_done(k[0]), 0);
      chk("reset_sum", obs_sum(k[0]), 0);
      chk("reset_ovf", obs_ovf(k[0]), 0);
      chk("reset_cout", obs_cout(k[0]), 0);
      chk("reset_state", obs_dbg(k[0]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 4-bit, one bit per clock
    run_op(1'b0, 'h2, 'h3, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 'h7, 'h5, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 'h7, 'h5, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 'hD, 'hB, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 'h9, 'h9, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 'h9, 'h9, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);

    // 8-bit, two bits per clock
    run_op(1'b1, 'h03, 'h05, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 'h80, 'h01, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 'h80, 'h01, 1'b1, 1'b1, 1'b0);
    run_op(1'b1, 'h7F, 'h80, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++)
      run_op(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0);
    run_op(1'b1, 'h10, 'h20, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 'h44, 'h11, 1'b0, 1'b0, 1'b0);

    // Abort with reset at the second RUN edge
    drive(1'b1, 1'b1, 'h55, 'h22, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 'h55, 'h22, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_before_abort", obs_busy(1'b1), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", obs_busy(1'b1), 0);
    chk("abort_done", obs_done(1'b1), 0);
    chk("abort_sum", obs_sum(1'b1), 0);
    chk("abort_ovf", obs_ovf(1'b1), 0);
    chk("abort_cout", obs_cout(1'b1), 0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      held_sum[k] = 0; held_ovf[k] = 1'b0; held_cout[k] = 1'b0;
    end
    repeat (6) begin
      @(negedge clk);
      chk("no_done_after_abort", obs_done(1'b1), 0);
      chk("idle_after_abort", obs_busy(1'b1), 0);
    end
    run_op(1'b1, 'h7F, 'h01, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
